serial_word_feeder: RTL

Upstream feeder for the 4-bit serial shift register stage. It accepts parallel words over a valid/ready handshake and buffers one pending word. It serialises each word LSB-first onto a single data line, paced by an internal clock-enable divider, and pulses a one-cycle strobe per bit. The downstream shift register samples `ser_data` on `ser_strobe`; after `WIDTH` strobes its parallel output equals the word sent.

---
 rtl/serial_word_feeder.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: one-word holding buffer in front of an LSB-first
// shifter, paced by a clock-enable divider with a strobe per bit.
module serial_word_feeder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 100_000_000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             ser_data,
  output logic             ser_strobe,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt;
  logic [DW-1:0]    r_div_cnt;

  logic w_accept;
  logic w_strobe;
  logic w_last;

  assign w_accept = in_valid && in_ready;
  assign w_strobe = (r_state == SHIFT) && (r_div_cnt == DIV_LAST);
  assign w_last   = w_strobe && (r_bit_cnt == BIT_LAST);

  assign in_ready   = !r_hold_full && !flush;
  assign ser_data   = (r_state == SHIFT) && r_shreg[0];
  assign ser_strobe = w_strobe;
  assign word_done  = w_last && !flush;
  assign busy       = (r_state == SHIFT) || r_hold_full;

  // Flush overrides everything; accept and load are mutually exclusive via in_ready.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_hold      <= in_data;
        r_hold_full <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_div_cnt <= '0;
          if (r_hold_full) begin
            r_shreg     <= r_hold;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          r_div_cnt <= w_strobe ? '0 : r_div_cnt + DW'(1);
          if (w_strobe) begin
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= r_bit_cnt + BW'(1);
            if (w_last) begin
              // Back-to-back reload keeps the strobe spacing at exactly DIV.
              if (r_hold_full) begin
                r_shreg     <= r_hold;
                r_hold_full <= 1'b0;
                r_bit_cnt   <= '0;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
